vx_dcache_port_sched: RTL and testbench

//  Shares the single core dcache request/response port between NUM_REQS execute-stage

---
 rtl/vx_dcache_arb_pkg.sv | 35 +++
 rtl/vx_rr_arbiter.sv | 50 +++++
 rtl/vx_dcache_port_sched.sv | 187 ++++++++++++++++++
 tb/tb_vx_dcache_port_sched.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_dcache_arb_pkg.sv
// Shared types and sizing helpers for the execute-stage dcache port scheduler.
package vx_dcache_arb_pkg;

    localparam int ARB_NUM_REQS     = 2;
    localparam int ARB_LANES        = 4;
    localparam int ARB_DATA_SIZE    = 4;
    localparam int ARB_ADDR_WIDTH   = 30;
    localparam int ARB_TAG_IN_WIDTH = 8;

    function automatic int req_bits(input int num_reqs);
        return (num_reqs > 1) ? $clog2(num_reqs) : 1;
    endfunction

    function automatic int tag_out_width(input int tag_in_width, input int num_reqs);
        return tag_in_width + req_bits(num_reqs);
    endfunction

    localparam int ARB_TAG_OUT_WIDTH = tag_out_width(ARB_TAG_IN_WIDTH, ARB_NUM_REQS);

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    // Buffered dcache request; the scheduler's width parameters must match these.
    typedef struct packed {
        logic                                 rw;
        logic [ARB_LANES-1:0]                 tmask;
        logic [ARB_LANES*ARB_DATA_SIZE-1:0]   byteen;
        logic [ARB_LANES*ARB_ADDR_WIDTH-1:0]  addr;
        logic [ARB_LANES*ARB_DATA_SIZE*8-1:0] data;
        logic [ARB_TAG_OUT_WIDTH-1:0]         tag;
    } req_t;

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, which moves past the winner
// only when the grant is actually consumed.
module vx_rr_arbiter import vx_dcache_arb_pkg::*; #(
    parameter  int NUM_REQS = 2,
    localparam int IDX_W    = req_bits(NUM_REQS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] eligible,
    input  logic                advance,
    output logic [NUM_REQS-1:0] grant,
    output logic [IDX_W-1:0]    grant_idx,
    output logic                grant_valid
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W:0]   cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQS))
                cand = cand - (IDX_W+1)'(NUM_REQS);
            if (!grant_valid && eligible[cand[IDX_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
        if (grant_valid)
            grant[grant_idx] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && grant_valid)
            ptr_d = (grant_idx == IDX_W'(NUM_REQS - 1)) ? '0 : grant_idx + IDX_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

endmodule

// File: rtl/vx_dcache_port_sched.sv
// Shares the core dcache port between execute-stage units: round-robin grant with a
// per-unit outstanding-read limit, one-entry output buffer, tag-steered responses.
module vx_dcache_port_sched import vx_dcache_arb_pkg::*; #(
    parameter  int NUM_REQS      = ARB_NUM_REQS,
    parameter  int LANES         = ARB_LANES,
    parameter  int DATA_SIZE     = ARB_DATA_SIZE,
    parameter  int ADDR_WIDTH    = ARB_ADDR_WIDTH,
    parameter  int TAG_IN_WIDTH  = ARB_TAG_IN_WIDTH,
    parameter  int TAG_SEL_IDX   = 0,
    parameter  int MAX_PENDING   = 16,
    localparam int REQ_BITS      = req_bits(NUM_REQS),
    localparam int TAG_OUT_WIDTH = tag_out_width(TAG_IN_WIDTH, NUM_REQS)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_REQS-1:0]                     req_valid_in,
    input  logic [NUM_REQS-1:0]                     req_rw_in,
    input  logic [NUM_REQS*LANES-1:0]               req_tmask_in,
    input  logic [NUM_REQS*LANES*DATA_SIZE-1:0]     req_byteen_in,
    input  logic [NUM_REQS*LANES*ADDR_WIDTH-1:0]    req_addr_in,
    input  logic [NUM_REQS*LANES*DATA_SIZE*8-1:0]   req_data_in,
    input  logic [NUM_REQS*TAG_IN_WIDTH-1:0]        req_tag_in,
    output logic [NUM_REQS-1:0]                     req_ready_in,
    output logic                                    req_valid_out,
    output logic                                    req_rw_out,
    output logic [LANES-1:0]                        req_tmask_out,
    output logic [LANES*DATA_SIZE-1:0]              req_byteen_out,
    output logic [LANES*ADDR_WIDTH-1:0]             req_addr_out,
    output logic [LANES*DATA_SIZE*8-1:0]            req_data_out,
    output logic [TAG_OUT_WIDTH-1:0]                req_tag_out,
    input  logic                                    req_ready_out,
    input  logic                                    rsp_valid_in,
    input  logic [LANES-1:0]                        rsp_tmask_in,
    input  logic [LANES*DATA_SIZE*8-1:0]            rsp_data_in,
    input  logic [TAG_OUT_WIDTH-1:0]                rsp_tag_in,
    output logic                                    rsp_ready_in,
    output logic [NUM_REQS-1:0]                     rsp_valid_out,
    output logic [LANES-1:0]                        rsp_tmask_out,
    output logic [LANES*DATA_SIZE*8-1:0]            rsp_data_out,
    output logic [TAG_IN_WIDTH-1:0]                 rsp_tag_out,
    input  logic [NUM_REQS-1:0]                     rsp_ready_out,
    output logic [NUM_REQS-1:0]                     pending_o
);

    localparam int CNT_W = $clog2(MAX_PENDING) + 1;
    localparam logic [TAG_OUT_WIDTH-1:0] LOW_MASK = (TAG_OUT_WIDTH'(1) << TAG_SEL_IDX) - TAG_OUT_WIDTH'(1);

    logic [NUM_REQS-1:0][LANES-1:0]              tmask_arr;
    logic [NUM_REQS-1:0][LANES*DATA_SIZE-1:0]    byteen_arr;
    logic [NUM_REQS-1:0][LANES*ADDR_WIDTH-1:0]   addr_arr;
    logic [NUM_REQS-1:0][LANES*DATA_SIZE*8-1:0]  data_arr;
    logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0]       tag_arr;

    assign tmask_arr  = req_tmask_in;
    assign byteen_arr = req_byteen_in;
    assign addr_arr   = req_addr_in;
    assign data_arr   = req_data_in;
    assign tag_arr    = req_tag_in;

    logic [NUM_REQS-1:0]            eligible, grant;
    logic [REQ_BITS-1:0]            grant_idx;
    logic                           grant_valid, accept;
    logic [TAG_OUT_WIDTH-1:0]       sel_tag;
    buf_state_e                     state_q, state_d;
    req_t                           buf_q, buf_d, req_sel;
    logic [NUM_REQS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [REQ_BITS-1:0]            rsp_idx;
    logic                           rsp_idx_ok;

    // Reads stall at the pending limit; writes never do.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQS; i++)
            eligible[i] = req_valid_in[i] && !(!req_rw_in[i] && cnt_q[i] == CNT_W'(MAX_PENDING));
    end

    vx_rr_arbiter #(.NUM_REQS(NUM_REQS)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .eligible    (eligible),
        .advance     (accept),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign accept       = grant_valid && (state_q == BUF_EMPTY || req_ready_out);
    assign req_ready_in = accept ? grant : '0;

    always_comb begin
        sel_tag        = TAG_OUT_WIDTH'(tag_arr[grant_idx]);
        req_sel        = '0;
        req_sel.rw     = req_rw_in[grant_idx];
        req_sel.tmask  = tmask_arr[grant_idx];
        req_sel.byteen = byteen_arr[grant_idx];
        req_sel.addr   = addr_arr[grant_idx];
        req_sel.data   = data_arr[grant_idx];
        req_sel.tag    = ((sel_tag >> TAG_SEL_IDX) << (TAG_SEL_IDX + REQ_BITS))
                       | (TAG_OUT_WIDTH'(grant_idx) << TAG_SEL_IDX)
                       | (sel_tag & LOW_MASK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= BUF_EMPTY;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUF_EMPTY: if (accept) state_d = BUF_FULL;
            BUF_FULL:  if (req_ready_out && !accept) state_d = BUF_EMPTY;
            default:   state_d = BUF_EMPTY;
        endcase
    end

    always_comb begin
        req_valid_out = (state_q == BUF_FULL);
        buf_d         = accept ? req_sel : buf_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            buf_q <= '0;
        else
            buf_q <= buf_d;
    end

    assign req_rw_out     = buf_q.rw;
    assign req_tmask_out  = buf_q.tmask;
    assign req_byteen_out = buf_q.byteen;
    assign req_addr_out   = buf_q.addr;
    assign req_data_out   = buf_q.data;
    assign req_tag_out    = buf_q.tag;

    // Responses route combinationally; an out-of-range index is swallowed.
    assign rsp_idx    = rsp_tag_in[TAG_SEL_IDX +: REQ_BITS];
    assign rsp_idx_ok = ({1'b0, rsp_idx} < (REQ_BITS+1)'(NUM_REQS));

    always_comb begin
        rsp_valid_out = '0;
        rsp_ready_in  = 1'b1;
        if (rsp_idx_ok) begin
            rsp_valid_out[rsp_idx] = rsp_valid_in;
            rsp_ready_in           = rsp_ready_out[rsp_idx];
        end
    end

    assign rsp_tmask_out = rsp_tmask_in;
    assign rsp_data_out  = rsp_data_in;
    assign rsp_tag_out   = TAG_IN_WIDTH'(((rsp_tag_in >> (TAG_SEL_IDX + REQ_BITS)) << TAG_SEL_IDX)
                                         | (rsp_tag_in & LOW_MASK));

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (req_ready_in[i] && !req_rw_in[i] && !(rsp_valid_out[i] && rsp_ready_out[i]))
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            else if (!(req_ready_in[i] && !req_rw_in[i]) && rsp_valid_out[i] && rsp_ready_out[i])
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    always_comb begin
        pending_o = '0;
        for (int i = 0; i < NUM_REQS; i++)
            pending_o[i] = (cnt_q[i] != '0);
    end

    a_rsp_idx_range: assert property (@(posedge clk) disable iff (reset)
        rsp_valid_in |-> rsp_idx_ok);

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_cnt_chk
        a_no_underflow: assert property (@(posedge clk) disable iff (reset)
            (rsp_valid_out[i] && rsp_ready_out[i]) |-> (cnt_q[i] != '0));
    end

endmodule

// File: tb/tb_vx_dcache_port_sched.sv
// Directed bench for the dcache port scheduler; request beats are scoreboarded
// and matched by a monitor on the dcache-side handshake.
module tb_vx_dcache_port_sched;

    typedef struct packed {
        logic         rw;
        logic [3:0]   tmask;
        logic [15:0]  byteen;
        logic [119:0] addr;
        logic [127:0] data;
        logic [8:0]   tag;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid_in, req_rw_in, req_ready_in;
    logic [7:0]   req_tmask_in;
    logic [31:0]  req_byteen_in;
    logic [239:0] req_addr_in;
    logic [255:0] req_data_in;
    logic [15:0]  req_tag_in;
    logic         req_valid_out, req_rw_out, req_ready_out;
    logic [3:0]   req_tmask_out;
    logic [15:0]  req_byteen_out;
    logic [119:0] req_addr_out;
    logic [127:0] req_data_out;
    logic [8:0]   req_tag_out;
    logic         rsp_valid_in, rsp_ready_in;
    logic [3:0]   rsp_tmask_in, rsp_tmask_out;
    logic [127:0] rsp_data_in, rsp_data_out;
    logic [8:0]   rsp_tag_in;
    logic [1:0]   rsp_valid_out, rsp_ready_out, pending_o;
    logic [7:0]   rsp_tag_out;

    int    n_pass = 0;
    int    n_tot  = 0;
    beat_t sb_q[$];
    beat_t mon_exp, mon_act;
    logic [7:0] tg [2];
    logic       rwv [2];

    always #5 clk = ~clk;

    vx_dcache_port_sched dut (
        .clk(clk), .reset(reset),
        .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_tmask_in(req_tmask_in),
        .req_byteen_in(req_byteen_in), .req_addr_in(req_addr_in), .req_data_in(req_data_in),
        .req_tag_in(req_tag_in), .req_ready_in(req_ready_in),
        .req_valid_out(req_valid_out), .req_rw_out(req_rw_out), .req_tmask_out(req_tmask_out),
        .req_byteen_out(req_byteen_out), .req_addr_out(req_addr_out), .req_data_out(req_data_out),
        .req_tag_out(req_tag_out), .req_ready_out(req_ready_out),
        .rsp_valid_in(rsp_valid_in), .rsp_tmask_in(rsp_tmask_in), .rsp_data_in(rsp_data_in),
        .rsp_tag_in(rsp_tag_in), .rsp_ready_in(rsp_ready_in),
        .rsp_valid_out(rsp_valid_out), .rsp_tmask_out(rsp_tmask_out), .rsp_data_out(rsp_data_out),
        .rsp_tag_out(rsp_tag_out), .rsp_ready_out(rsp_ready_out), .pending_o(pending_o)
    );

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Beat contents are a fixed function of (requester, tag, rw).
    function automatic beat_t mk(input int i, input logic [7:0] t, input logic rw);
        beat_t b;
        b.rw     = rw;
        b.tmask  = t[3:0] | 4'h1;
        b.byteen = {t, t} ^ 16'hF00F;
        for (int l = 0; l < 4; l++) begin
            b.addr[l*30 +: 30]  = {6'(i), t, 8'(l), 8'h5A};
            b.data[l*32 +: 32]  = {t, 8'(i), 8'(l), 8'hC3};
        end
        b.tag = {t, 1'(i)};
        return b;
    endfunction

    task automatic drive(input logic [1:0] v);
        beat_t b;
        req_valid_in = v;
        for (int i = 0; i < 2; i++) begin
            b = mk(i, tg[i], rwv[i]);
            req_rw_in[i]                = b.rw;
            req_tmask_in[i*4 +: 4]      = b.tmask;
            req_byteen_in[i*16 +: 16]   = b.byteen;
            req_addr_in[i*120 +: 120]   = b.addr;
            req_data_in[i*128 +: 128]   = b.data;
            req_tag_in[i*8 +: 8]        = tg[i];
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(2'b00);
        rsp_valid_in = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && req_valid_out && req_ready_out) begin
            if (sb_q.size() == 0) begin
                n_tot++;
                $display("FAIL req_out_unexpected: got tag %0h expected no beat", req_tag_out);
            end else begin
                mon_exp = sb_q.pop_front();
                mon_act.rw     = req_rw_out;
                mon_act.tmask  = req_tmask_out;
                mon_act.byteen = req_byteen_out;
                mon_act.addr   = req_addr_out;
                mon_act.data   = req_data_out;
                mon_act.tag    = req_tag_out;
                chk("req_out_beat", 512'(mon_act), 512'(mon_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int    g;
        beat_t hb;
        reset = 1'b1;
        tg[0] = 8'h00; tg[1] = 8'h00; rwv[0] = 1'b0; rwv[1] = 1'b0;
        drive(2'b00);
        req_ready_out = 1'b1;
        rsp_valid_in  = 1'b0;
        rsp_tmask_in  = 4'h9;
        rsp_data_in   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        rsp_tag_in    = '0;
        rsp_ready_out = 2'b00;

        @(negedge clk);
        chk("rst_valid_out", 512'(req_valid_out), 512'(1'b0));
        chk("rst_pending", 512'(pending_o), 512'(2'b00));
        do_reset();

        // 1: alternating grants
        tg[0] = 8'h10; tg[1] = 8'h20;
        for (int k = 0; k < 8; k++) begin
            g = k % 2;
            drive(2'b11);
            @(negedge clk);
            chk("t1_grant", 512'(req_ready_in), 512'((g == 1) ? 2'b10 : 2'b01));
            sb_q.push_back(mk(g, tg[g], 1'b0));
            cyc();
            tg[g] = tg[g] + 8'd1;
        end
        drive(2'b00);
        @(negedge clk);
        chk("t1_pending", 512'(pending_o), 512'(2'b11));
        cyc();
        @(negedge clk);
        chk("t1_drained", 512'(req_valid_out), 512'(1'b0));
        cyc();
        do_reset();
        @(negedge clk);
        chk("t1_rst_clears_cnt", 512'(pending_o), 512'(2'b00));
        cyc();

        // 2: LSU pending limit
        tg[0] = 8'h40;
        for (int k = 0; k < 16; k++) begin
            drive(2'b01);
            @(negedge clk);
            chk("t2_lsu_fill", 512'(req_ready_in), 512'(2'b01));
            sb_q.push_back(mk(0, tg[0], 1'b0));
            cyc();
            tg[0] = tg[0] + 8'd1;
        end
        drive(2'b01);
        @(negedge clk);
        chk("t2_lsu_throttled", 512'(req_ready_in), 512'(2'b00));
        chk("t2_pending", 512'(pending_o), 512'(2'b01));
        cyc();
        tg[1] = 8'h60;
        drive(2'b11);
        @(negedge clk);
        chk("t2_tex_passes", 512'(req_ready_in), 512'(2'b10));
        sb_q.push_back(mk(1, tg[1], 1'b0));
        cyc();
        tg[1] = tg[1] + 8'd1;
        rwv[0] = 1'b1;
        drive(2'b01);
        @(negedge clk);
        chk("t2_lsu_write_passes", 512'(req_ready_in), 512'(2'b01));
        sb_q.push_back(mk(0, tg[0], 1'b1));
        cyc();
        tg[0] = tg[0] + 8'd1;
        rwv[0] = 1'b0;
        drive(2'b01);
        rsp_valid_in  = 1'b1;
        rsp_tag_in    = {8'h40, 1'b0};
        rsp_ready_out = 2'b01;
        @(negedge clk);
        chk("t2_rsp_valid", 512'(rsp_valid_out), 512'(2'b01));
        chk("t2_rsp_ready", 512'(rsp_ready_in), 512'(1'b1));
        chk("t2_still_full", 512'(req_ready_in), 512'(2'b00));
        cyc();
        rsp_valid_in  = 1'b0;
        rsp_ready_out = 2'b00;
        drive(2'b01);
        @(negedge clk);
        chk("t2_lsu_resumes", 512'(req_ready_in), 512'(2'b01));
        sb_q.push_back(mk(0, tg[0], 1'b0));
        cyc();
        tg[0] = tg[0] + 8'd1;
        drive(2'b00);
        cyc();
        cyc();
        do_reset();

        // 3: back-pressure holds the output buffer
        tg[0] = 8'h80;
        drive(2'b01);
        @(negedge clk);
        chk("t3_first", 512'(req_ready_in), 512'(2'b01));
        sb_q.push_back(mk(0, tg[0], 1'b0));
        cyc();
        tg[0] = tg[0] + 8'd1;
        req_ready_out = 1'b0;
        drive(2'b01);
        hb = mk(0, 8'h80, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_hold_ready_in", 512'(req_ready_in), 512'(2'b00));
            chk("t3_hold_valid", 512'(req_valid_out), 512'(1'b1));
            chk("t3_hold_tag", 512'(req_tag_out), 512'(9'h100));
            chk("t3_hold_addr", 512'(req_addr_out), 512'(hb.addr));
            cyc();
        end
        req_ready_out = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(2'b01);
            @(negedge clk);
            chk("t3_resume", 512'(req_ready_in), 512'(2'b01));
            chk("t3_resume_valid", 512'(req_valid_out), 512'(1'b1));
            sb_q.push_back(mk(0, tg[0], 1'b0));
            cyc();
            tg[0] = tg[0] + 8'd1;
        end
        drive(2'b00);
        cyc();
        cyc();

        // 4: response steering and tag stripping (LSU holds 5 pending)
        tg[1] = 8'hD2;
        drive(2'b10);
        @(negedge clk);
        chk("t4_tex_req", 512'(req_ready_in), 512'(2'b10));
        sb_q.push_back(mk(1, tg[1], 1'b0));
        cyc();
        tg[1] = tg[1] + 8'd1;
        drive(2'b00);
        rsp_valid_in  = 1'b1;
        rsp_tag_in    = 9'h1A5;
        rsp_tmask_in  = 4'hA;
        rsp_ready_out = 2'b01;
        @(negedge clk);
        chk("t4_rsp_valid", 512'(rsp_valid_out), 512'(2'b10));
        chk("t4_rsp_tag", 512'(rsp_tag_out), 512'(8'hD2));
        chk("t4_rsp_stall", 512'(rsp_ready_in), 512'(1'b0));
        chk("t4_rsp_tmask", 512'(rsp_tmask_out), 512'(4'hA));
        chk("t4_rsp_data", 512'(rsp_data_out), 512'(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210));
        chk("t4_pending", 512'(pending_o), 512'(2'b11));
        cyc();
        rsp_ready_out = 2'b11;
        @(negedge clk);
        chk("t4_rsp_ready", 512'(rsp_ready_in), 512'(1'b1));
        cyc();
        rsp_valid_in  = 1'b0;
        rsp_ready_out = 2'b00;
        @(negedge clk);
        chk("t4_tex_done", 512'(pending_o), 512'(2'b01));
        cyc();

        // 5: simultaneous LSU accept and LSU response keeps the count at 5
        tg[0] = 8'hE0;
        drive(2'b01);
        rsp_valid_in  = 1'b1;
        rsp_tag_in    = {8'h80, 1'b0};
        rsp_ready_out = 2'b01;
        @(negedge clk);
        chk("t5_accept", 512'(req_ready_in), 512'(2'b01));
        chk("t5_rsp_ready", 512'(rsp_ready_in), 512'(1'b1));
        sb_q.push_back(mk(0, tg[0], 1'b0));
        cyc();
        tg[0] = tg[0] + 8'd1;
        drive(2'b00);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5_pending_drain", 512'(pending_o[0]), 512'(1'b1));
            cyc();
        end
        rsp_valid_in  = 1'b0;
        rsp_ready_out = 2'b00;
        @(negedge clk);
        chk("t5_pending_zero", 512'(pending_o), 512'(2'b00));
        cyc();

        // 6: async reset with buffer FULL and cnt=3; the held third beat is dropped
        tg[0] = 8'hF0;
        for (int k = 0; k < 3; k++) begin
            drive(2'b01);
            @(negedge clk);
            chk("t6_fill", 512'(req_ready_in), 512'(2'b01));
            if (k < 2) sb_q.push_back(mk(0, tg[0], 1'b0));
            cyc();
            tg[0] = tg[0] + 8'd1;
        end
        drive(2'b00);
        req_ready_out = 1'b0;
        @(negedge clk);
        chk("t6_full_before_rst", 512'(req_valid_out), 512'(1'b1));
        chk("t6_cnt_before_rst", 512'(pending_o), 512'(2'b01));
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_valid_out", 512'(req_valid_out), 512'(1'b0));
        chk("t6_rst_pending", 512'(pending_o), 512'(2'b00));
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_ready_out = 1'b1;
        tg[1] = 8'hF8;
        drive(2'b11);
        @(negedge clk);
        chk("t6_first_grant", 512'(req_ready_in), 512'(2'b01));
        sb_q.push_back(mk(0, tg[0], 1'b0));
        cyc();
        tg[0] = tg[0] + 8'd1;
        drive(2'b00);
        cyc();
        cyc();

        @(negedge clk);
        chk("sb_empty", 512'(sb_q.size()), 512'(0));
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
